// File: rtl/bcd_down_counter_if.sv
// Control/data bundle for bcd_down_counter: decrement/load requests in,
// packed BCD count and status flags out.
interface bcd_down_counter_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] valor;
  logic         borrow;
  logic         zero;

  // Requester side (control FSM or testbench)
  modport master (
    output enable, load, load_value,
    input  valor, borrow, zero
  );

  // Counter side
  modport slave (
    input  enable, load, load_value,
    output valor, borrow, zero
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down-counter with a one-cycle borrow pulse on the
// wrap out of all-zeros. Digit k sits in bits [4k+3:4k], digit 0 is the LSD.
// Optional build macro BCD_DOWN_RELOAD_EN: the wrap reloads the clamped
// load_value instead of all-9s, turning the block into a periodic reload timer.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 2
) (
  input logic              clock,
  input logic              reset,
  bcd_down_counter_if.slave bus
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_nxt;
  logic [W-1:0] clamped;
  logic [W-1:0] decremented;
  logic         borrow_q;
  logic         borrow_nxt;
  logic         borrow_chain;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Per-digit clamp of the preload so valor never holds a non-BCD digit
  always_comb begin
    clamped = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      clamped[4*k +: 4] = clamp_digit(bus.load_value[4*k +: 4]);
    end
  end

  // Borrow chain resolved in one cycle; a digit moves only if all lower digits were 0.
  // When the chain survives every digit the count was zero and the result is all-9s.
  always_comb begin
    decremented  = valor_q;
    borrow_chain = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (borrow_chain) begin
        if (valor_q[4*k +: 4] == 4'd0) begin
          decremented[4*k +: 4] = 4'd9;
        end else begin
          decremented[4*k +: 4] = valor_q[4*k +: 4] - 4'd1;
          borrow_chain          = 1'b0;
        end
      end
    end
  end

  // Next-state selection: load, then decrement/wrap, then hold
  always_comb begin
    valor_nxt  = valor_q;
    borrow_nxt = 1'b0;
    if (bus.load) begin
      valor_nxt = clamped;
    end else if (bus.enable) begin
      borrow_nxt = borrow_chain;
`ifdef BCD_DOWN_RELOAD_EN
      valor_nxt  = borrow_chain ? clamped : decremented;
`else
      valor_nxt  = decremented;
`endif
    end
  end

  // Count and borrow registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      valor_q  <= valor_nxt;
      borrow_q <= borrow_nxt;
    end
  end

  assign bus.valor  = valor_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = (valor_q == W'(0));

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=2). The reference model
// keeps the count as a plain integer 0..99 and converts to/from packed BCD.
module tb_bcd_down_counter;
  localparam int unsigned DIGITS = 2;
  localparam int MAXV = 99;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int   model_n = 0;
  bit   model_b = 1'b0;

  bcd_down_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int clamp_int(input logic [7:0] v);
    int t;
    int o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  // Advance the model from the currently driven inputs, then clock the DUT
  task automatic tick();
    int nn;
    bit nb;
    nn = model_n;
    nb = 1'b0;
    if (bus.load) begin
      nn = clamp_int(bus.load_value);
    end else if (bus.enable) begin
      if (model_n == 0) begin
`ifdef BCD_DOWN_RELOAD_EN
        nn = clamp_int(bus.load_value);
`else
        nn = MAXV;
`endif
        nb = 1'b1;
      end else begin
        nn = model_n - 1;
      end
    end
    @(posedge clock);
    #1;
    model_n = nn;
    model_b = nb;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load       = 1'b1;
    bus.enable     = 1'b0;
    bus.load_value = v;
    tick();
    bus.load       = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    model_n = 0;
    model_b = 1'b0;
    checks++;
    if (bus.valor !== 8'h00 || bus.borrow !== 1'b0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valor=%h borrow=%b zero=%b, required 00/0/1",
               bus.valor, bus.borrow, bus.zero);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h47);
    checks++;
    if (bus.valor !== 8'h47) begin
      errors++;
      $display("FAIL async_reset_preload: valor=%h required 47", bus.valor);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.valor !== 8'h00 || bus.borrow !== 1'b0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_midcycle: valor=%h borrow=%b zero=%b, required 00/0/1",
               bus.valor, bus.borrow, bus.zero);
    end
    @(negedge clock);
    reset   = 1'b0;
    model_n = 0;
    model_b = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_load_clamp();
    do_load(8'hAF);
    checks++;
    if (bus.valor !== 8'h99 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp_AF: valor=%h borrow=%b, required 99/0", bus.valor, bus.borrow);
    end
    do_load(8'hA3);
    checks++;
    if (bus.valor !== 8'h93) begin
      errors++;
      $display("FAIL load_clamp_A3: valor=%h required 93", bus.valor);
    end
    do_load(8'h20);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.valor !== 8'h19 || bus.valor !== to_bcd(model_n) || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL digit_borrow_20: valor=%h borrow=%b, required 19/0", bus.valor, bus.borrow);
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h02;
    exp_seq[1] = 8'h01;
    exp_seq[2] = 8'h00;
`ifdef BCD_DOWN_RELOAD_EN
    exp_seq[3] = 8'h03;
`else
    exp_seq[3] = 8'h99;
`endif
    do_load(8'h03);
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.valor !== exp_seq[i] || bus.borrow !== (i == 3) ||
          bus.zero !== (i == 2)) begin
        errors++;
        $display("FAIL countdown_step%0d: valor=%h borrow=%b zero=%b, required %h/%b/%b",
                 i, bus.valor, bus.borrow, bus.zero, exp_seq[i], (i == 3), (i == 2));
      end
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.borrow !== 1'b0 || bus.valor !== exp_seq[3]) begin
      errors++;
      $display("FAIL countdown_borrow_fall: valor=%h borrow=%b, required %h/0",
               bus.valor, bus.borrow, exp_seq[3]);
    end
  endtask

  task automatic test_reload();
    do_load(8'h00);
    bus.load_value = 8'h05;
    bus.enable     = 1'b1;
    tick();
    checks++;
    if (bus.valor !== to_bcd(model_n) || bus.borrow !== 1'b1) begin
      errors++;
      $display("FAIL wrap_from_zero: valor=%h borrow=%b, required %h/1",
               bus.valor, bus.borrow, to_bcd(model_n));
    end
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.valor !== to_bcd(model_n) || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse_width: valor=%h borrow=%b, required %h/0",
               bus.valor, bus.borrow, to_bcd(model_n));
    end
  endtask

  task automatic test_collision();
    do_load(8'h00);
    bus.load       = 1'b1;
    bus.enable     = 1'b1;
    bus.load_value = 8'h12;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    checks++;
    if (bus.valor !== 8'h12 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL load_enable_collision: valor=%h borrow=%b, required 12/0",
               bus.valor, bus.borrow);
    end
  endtask

  task automatic test_hold();
    do_load(8'h36);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.load_value = 8'($urandom);
      tick();
      checks++;
      if (bus.valor !== 8'h36 || bus.borrow !== 1'b0 || bus.zero !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valor=%h borrow=%b zero=%b, required 36/0/0",
                 i, bus.valor, bus.borrow, bus.zero);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.load       = ($urandom_range(99, 0) < 3);
      bus.enable     = ($urandom_range(99, 0) < 75);
      bus.load_value = ($urandom_range(3, 0) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(12, 0)));
      tick();
      checks++;
      if (bus.valor !== to_bcd(model_n) || bus.borrow !== model_b ||
          bus.zero !== (model_n == 0)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: valor=%h borrow=%b zero=%b, required %h/%b/%b",
                   i, bus.valor, bus.borrow, bus.zero, to_bcd(model_n), model_b, (model_n == 0));
      end
    end
    bus.load   = 1'b0;
    bus.enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_load_clamp();
    test_countdown();
    test_reload();
    test_collision();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
